mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer for the 16-bit CPU; successor to the fixed-latency control FSM.
- Sequences IFETCH/IDEC/EXEC/MEM/WB and drives datapath load strobes from instruction-class flags supplied by a separate decoder.
- Adds a memory ready handshake with wait states and a timeout fault, an optional MEM-skip fast path, interrupt entry at instruction boundaries, HALT exit by interrupt, and a retired-instruction counter.

Parameters:
- SKIP_MEM, 0: when 1, instructions that are not load/store and not nowb go EXEC->WB directly.
- TIMEOUT, 15: maximum wait cycles for mem_ack in a request state; 0 disables the timeout.
- TMO_W, 4: width of the wait counter; must satisfy TIMEOUT < 2^TMO_W.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cls_load  in  1  decoded instruction is a load (LW-class)
- cls_store  in  1  decoded instruction is a store (SW-class)
- cls_nowb  in  1  instruction has no register writeback (branch, store, JR-class)
- cls_halt  in  1  decoded instruction is HLT
- mem_ack  in  1  memory completes the current request this cycle
- irq  in  1  level interrupt request
- irq_mask  in  1  1 = interrupts blocked
- mem_req  out  1  memory request active
- mem_we  out  1  write request (valid only with mem_req)
- mem_ifetch  out  1  request is an instruction fetch
- load_ir, load_npc  out  1  capture instruction / next PC
- load_ops  out  1  load RegA/RegB/Imm
- load_alu  out  1  capture ALU result
- load_lmd  out  1  capture load data
- load_pc  out  1  update PC
- reg_we  out  1  register-file write
- irq_take  out  1  interrupt accepted this cycle
- fault  out  1  sticky memory timeout
- state  out  3  current state
- instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: IDLE=0, IFETCH=1, IDEC=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7. State and counters are registered; strobes decode combinationally from state, the cls_* flags and mem_ack.
- Reset (rst=0, any time, including mid-request): state=IDLE, wait counter=0, instret=0, fault=0. Every strobe is 0 while in IDLE.
- IDLE: 1 cycle, then IFETCH.
- IFETCH: mem_req=1, mem_ifetch=1, mem_we=0, held until mem_ack. In the mem_ack cycle load_ir=load_npc=1 and the next state is IDEC. No strobe fires without ack.
- IDEC: load_ops=1 for 1 cycle. Next state is HALT if cls_halt, else EXEC.
- EXEC: load_alu=1 for 1 cycle. Next state:
  - MEM if cls_load|cls_store, or SKIP_MEM=0, or cls_nowb;
  - otherwise WB.
- MEM, load/store: mem_req=1, mem_we=cls_store, mem_ifetch=0, held until mem_ack. load_lmd=mem_ack&cls_load.
- MEM, other instructions: pass-through for 1 cycle, mem_req=0.
- MEM completion cycle: load_pc=1. Next state is IFETCH if cls_nowb, else WB.
- WB: reg_we=1 for 1 cycle, then IFETCH. load_pc=1 in WB only when MEM was skipped.
- Retirement: the cycle that transitions into IFETCH from MEM or WB. instret increments by 1 and wraps modulo 2^CNT_W.
- Interrupt: in a retirement cycle, if irq=1 and irq_mask=0, irq_take=1 for that cycle. The external PC mux vectors on irq_take, and the next state is still IFETCH.
- HALT: all strobes 0. Remains in HALT until irq=1 and irq_mask=0, then irq_take=1 and the next state is IFETCH. HALT does not increment instret.
- Wait counter:
  - clears on entry to IFETCH or MEM;
  - increments each cycle mem_req=1 and mem_ack=0;
  - if TIMEOUT≠0 and the counter equals TIMEOUT with mem_ack=0, next state is FAULT.
  - mem_ack in the same cycle as the limit wins: normal completion.
- FAULT: fault=1, all other strobes 0. Exits only via reset.
- The cls_* flags must be stable from IDEC through WB; they are not registered internally.
- irq asserted mid-instruction has no effect until the retirement cycle.

Test Plan:
- ALU op (cls all 0), SKIP_MEM=0, mem_ack tied 1:
  - states 1,2,3,4,5,1;
  - 5 cycles per instruction;
  - reg_we in state 5; load_pc in state 4;
  - instret 0→1.
- Same op with SKIP_MEM=1: states 1,2,3,5,1; load_pc and reg_we both in WB; 4 cycles; instret +1.
- Load with mem_ack delayed 3 cycles in MEM:
  - mem_req high 4 cycles;
  - mem_we=0;
  - load_lmd exactly in the ack cycle;
  - then WB, reg_we=1.
- Store, TIMEOUT=15, mem_ack never asserted:
  - after 15 wait cycles state=7, fault=1, mem_req=0;
  - rst low clears state=0 and fault=0.
- Branch (cls_nowb) with irq=1, irq_mask=0:
  - MEM→IFETCH directly, no reg_we;
  - irq_take=1 in the retirement cycle;
  - with irq_mask=1, no irq_take.
- HLT instruction:
  - state=6 and holds for 20 cycles with no strobes and instret constant;
  - irq pulse gives irq_take=1, then IFETCH;
  - with CNT_W=4, 16 retirements wrap instret from 15 to 0.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU: walks IFETCH/IDEC/EXEC/MEM/WB,
// handles memory wait states with a timeout fault, interrupt entry, HALT and instret.
module mc_sequencer #(
  parameter int SKIP_MEM = 0,
  parameter int TIMEOUT  = 15,
  parameter int TMO_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cls_load,
  input  logic             cls_store,
  input  logic             cls_nowb,
  input  logic             cls_halt,
  input  logic             mem_ack,
  input  logic             irq,
  input  logic             irq_mask,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_ifetch,
  output logic             load_ir,
  output logic             load_npc,
  output logic             load_ops,
  output logic             load_alu,
  output logic             load_lmd,
  output logic             load_pc,
  output logic             reg_we,
  output logic             irq_take,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_IFETCH = 3'd1,
    S_IDEC   = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [TMO_W-1:0] r_wait;
  logic [CNT_W-1:0] r_instret;
  logic             w_memop;
  logic             w_skip;
  logic             w_limit;
  logic             w_retire;
  logic             w_done;
  logic             w_irq_ok;

  assign w_memop  = cls_load | cls_store;
  // MEM is bypassed only for plain register-writing ops when the fast path is built in
  assign w_skip   = (SKIP_MEM != 0) && !w_memop && !cls_nowb;
  assign w_limit  = (TIMEOUT != 0) && (r_wait == LIMIT);
  assign w_irq_ok = irq & ~irq_mask;

  assign state   = r_state;
  assign instret = r_instret;

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_done     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    load_ir    = 1'b0;
    load_npc   = 1'b0;
    load_ops   = 1'b0;
    load_alu   = 1'b0;
    load_lmd   = 1'b0;
    load_pc    = 1'b0;
    reg_we     = 1'b0;
    irq_take   = 1'b0;
    fault      = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_IFETCH;
      S_IFETCH: begin
        mem_req    = 1'b1;
        mem_ifetch = 1'b1;
        if (mem_ack) begin
          load_ir  = 1'b1;
          load_npc = 1'b1;
          w_next   = S_IDEC;
        end else if (w_limit) begin
          w_next = S_FAULT;
        end
      end
      S_IDEC: begin
        load_ops = 1'b1;
        w_next   = cls_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        load_alu = 1'b1;
        w_next   = w_skip ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (w_memop) begin
          mem_req = 1'b1;
          mem_we  = cls_store;
          if (mem_ack) begin
            load_lmd = cls_load;
            w_done   = 1'b1;
          end else if (w_limit) begin
            w_next = S_FAULT;
          end
        end else begin
          w_done = 1'b1;
        end
        if (w_done) begin
          load_pc = 1'b1;
          if (cls_nowb) begin
            w_next   = S_IFETCH;
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we   = 1'b1;
        load_pc  = w_skip;
        w_next   = S_IFETCH;
        w_retire = 1'b1;
      end
      S_HALT: begin
        if (w_irq_ok) begin
          irq_take = 1'b1;
          w_next   = S_IFETCH;
        end
      end
      S_FAULT: fault = 1'b1;
      default: w_next = S_IDLE;
    endcase
    // Interrupts are only taken at an instruction boundary
    if (w_retire && w_irq_ok) irq_take = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next == S_IFETCH || w_next == S_MEM) && (w_next != r_state)) begin
        r_wait <= '0;
      end else if (mem_req && !mem_ack && (r_wait != '1)) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: an instruction-level model expands each instruction into the
// expected per-cycle trace, which is replayed against the DUT (two parameter sets).
module tb_mc_sequencer;

  localparam int TMO = 15;
  localparam logic [14:0] TAKE = 15'h001, RWE = 15'h002, PC  = 15'h004, LMD = 15'h008,
                          ALU  = 15'h010, OPS = 15'h020, NPC = 15'h040, IR  = 15'h080,
                          IFE  = 15'h100, WE  = 15'h200, REQ = 15'h400, FLT = 15'h800;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cls_load = 0, cls_store = 0, cls_nowb = 0, cls_halt = 0;
  logic mem_ack = 0, irq = 0, irq_mask = 0;

  logic mem_req0, mem_we0, mem_ifetch0, load_ir0, load_npc0, load_ops0, load_alu0;
  logic load_lmd0, load_pc0, reg_we0, irq_take0, fault0;
  logic [2:0] state0;
  logic [3:0] instret0;
  logic mem_req1, mem_we1, mem_ifetch1, load_ir1, load_npc1, load_ops1, load_alu1;
  logic load_lmd1, load_pc1, reg_we1, irq_take1, fault1;
  logic [2:0] state1;
  logic [15:0] instret1;
  logic [14:0] obs0, obs1;

  assign obs0 = {state0, fault0, mem_req0, mem_we0, mem_ifetch0, load_ir0, load_npc0,
                 load_ops0, load_alu0, load_lmd0, load_pc0, reg_we0, irq_take0};
  assign obs1 = {state1, fault1, mem_req1, mem_we1, mem_ifetch1, load_ir1, load_npc1,
                 load_ops1, load_alu1, load_lmd1, load_pc1, reg_we1, irq_take1};

  always #5 clk = ~clk;

  mc_sequencer #(.SKIP_MEM(0), .TIMEOUT(TMO), .TMO_W(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .cls_load(cls_load), .cls_store(cls_store), .cls_nowb(cls_nowb),
    .cls_halt(cls_halt), .mem_ack(mem_ack), .irq(irq), .irq_mask(irq_mask),
    .mem_req(mem_req0), .mem_we(mem_we0), .mem_ifetch(mem_ifetch0), .load_ir(load_ir0),
    .load_npc(load_npc0), .load_ops(load_ops0), .load_alu(load_alu0), .load_lmd(load_lmd0),
    .load_pc(load_pc0), .reg_we(reg_we0), .irq_take(irq_take0), .fault(fault0),
    .state(state0), .instret(instret0));

  mc_sequencer #(.SKIP_MEM(1), .TIMEOUT(TMO), .TMO_W(4), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .cls_load(cls_load), .cls_store(cls_store), .cls_nowb(cls_nowb),
    .cls_halt(cls_halt), .mem_ack(mem_ack), .irq(irq), .irq_mask(irq_mask),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_ifetch(mem_ifetch1), .load_ir(load_ir1),
    .load_npc(load_npc1), .load_ops(load_ops1), .load_alu(load_alu1), .load_lmd(load_lmd1),
    .load_pc(load_pc1), .reg_we(reg_we1), .irq_take(irq_take1), .fault(fault1),
    .state(state1), .instret(instret1));

  typedef struct {
    logic        ack;
    logic        irq;
    logic        mask;
    logic [3:0]  cls;
    logic [14:0] exp;
    int          inst;
  } ent_t;

  ent_t       q[$];
  logic [3:0] g_cls;
  int         m_inst;
  int         n_checks = 0;
  int         n_errors = 0;
  string      tname;

  function automatic logic [14:0] st_v(input int s);
    return {3'(s), 12'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic a, input logic i, input logic m, input logic [14:0] x);
    ent_t e;
    e.ack = a; e.irq = i; e.mask = m; e.cls = g_cls; e.exp = x; e.inst = m_inst;
    q.push_back(e);
  endtask

  task automatic push_fault();
    for (int k = 0; k < 3; k++) push(rb(), rb(), rb(), st_v(7) | FLT);
  endtask

  // Expands one instruction into its expected cycle trace; fd/md = ack delays in cycles.
  task automatic gen_instr(input bit skip, input bit ld, input bit st, input bit nowb,
                           input bit hlt, input int fd, input int md,
                           input bit ri, input bit rm);
    logic [14:0] last;
    logic        take;
    g_cls = {ld, st, nowb, hlt};
    take  = ri & ~rm;
    for (int k = 0; k < fd && k <= TMO; k++) push(1'b0, rb(), rb(), st_v(1) | REQ | IFE);
    if (fd > TMO) begin push_fault(); return; end
    push(1'b1, rb(), rb(), st_v(1) | REQ | IFE | IR | NPC);
    push(rb(), rb(), rb(), st_v(2) | OPS);
    if (hlt) begin
      for (int k = 0; k < 20; k++) begin
        logic i;
        i = rb();
        push(rb(), i, i ? 1'b1 : rb(), st_v(6));
      end
      push(rb(), 1'b1, 1'b0, st_v(6) | TAKE);
      return;
    end
    push(rb(), rb(), rb(), st_v(3) | ALU);
    if ((ld | st) || !skip || nowb) begin
      if (ld | st) begin
        for (int k = 0; k < md && k <= TMO; k++)
          push(1'b0, rb(), rb(), st_v(4) | REQ | (st ? WE : 15'h0));
        if (md > TMO) begin push_fault(); return; end
        last = st_v(4) | REQ | (st ? WE : 15'h0) | (ld ? LMD : 15'h0) | PC;
      end else begin
        last = st_v(4) | PC;
      end
      if (nowb) begin
        push(1'b1, ri, rm, last | (take ? TAKE : 15'h0));
      end else begin
        push(1'b1, rb(), rb(), last);
        push(rb(), ri, rm, st_v(5) | RWE | (take ? TAKE : 15'h0));
      end
    end else begin
      push(rb(), ri, rm, st_v(5) | RWE | PC | (take ? TAKE : 15'h0));
    end
    m_inst++;
  endtask

  task automatic run_q(input bit sel);
    ent_t        e;
    logic [14:0] obs;
    int          got_i, exp_i;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      {cls_load, cls_store, cls_nowb, cls_halt} = e.cls;
      mem_ack = e.ack; irq = e.irq; irq_mask = e.mask;
      #1;
      obs   = sel ? obs1 : obs0;
      got_i = sel ? int'(instret1) : int'(instret0);
      exp_i = sel ? (e.inst % 65536) : (e.inst % 16);
      n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL %s dut%0d trace: got state/strobes %b, expected %b", tname, sel, obs, e.exp);
      end
      n_checks++;
      if (got_i !== exp_i) begin
        n_errors++;
        $display("FAIL %s dut%0d instret: got %0d, expected %0d", tname, sel, got_i, exp_i);
      end
    end
  endtask

  task automatic do_reset();
    mem_ack = 0; irq = 0; irq_mask = 0;
    {cls_load, cls_store, cls_nowb, cls_halt} = 4'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_inst = 0;
  endtask

  task automatic test_reset();
    tname = "reset";
    do_reset();
    #1;
    n_checks++;
    if (obs0 !== 15'h0 || instret0 !== 4'd0) begin
      n_errors++; $display("FAIL reset_idle0: got %b/%0d, expected 0/0", obs0, instret0);
    end
    n_checks++;
    if (obs1 !== 15'h0 || instret1 !== 16'd0) begin
      n_errors++; $display("FAIL reset_idle1: got %b/%0d, expected 0/0", obs1, instret1);
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (obs0 !== (st_v(1) | REQ | IFE)) begin
      n_errors++; $display("FAIL reset_wait_fetch: got %b, expected %b", obs0, st_v(1) | REQ | IFE);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (obs0 !== 15'h0 || obs1 !== 15'h0) begin
      n_errors++; $display("FAIL reset_async_midreq: got %b %b, expected all zero", obs0, obs1);
    end
  endtask

  task automatic test_alu();
    tname = "alu_noskip";
    do_reset();
    gen_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    gen_instr(0, 0, 0, 0, 0, 2, 0, 1, 1);
    run_q(0);
    tname = "alu_skip";
    do_reset();
    gen_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
    gen_instr(1, 0, 0, 0, 0, 1, 0, 0, 0);
    run_q(1);
  endtask

  task automatic test_load_wait();
    tname = "load_wait";
    do_reset();
    gen_instr(0, 1, 0, 0, 0, 0, 3, 0, 0);
    gen_instr(1, 1, 0, 0, 0, 1, TMO, 0, 0);
    run_q(1);
    tname = "load_limit";
    do_reset();
    gen_instr(0, 1, 0, 0, 0, TMO, TMO, 0, 0);
    run_q(0);
  endtask

  task automatic test_timeout();
    tname = "store_timeout";
    do_reset();
    gen_instr(0, 0, 1, 1, 0, 0, 1000, 0, 0);
    run_q(0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs0 !== 15'h0 || instret0 !== 4'd0) begin
      n_errors++; $display("FAIL fault_reset: got %b/%0d, expected 0/0", obs0, instret0);
    end
    tname = "fetch_timeout";
    do_reset();
    gen_instr(1, 0, 0, 0, 0, 40, 0, 0, 0);
    run_q(1);
  endtask

  task automatic test_branch_irq();
    tname = "branch_irq";
    do_reset();
    gen_instr(0, 0, 0, 1, 0, 0, 0, 1, 0);
    gen_instr(0, 0, 0, 1, 0, 1, 0, 1, 1);
    gen_instr(0, 0, 0, 0, 0, 0, 0, 1, 0);
    run_q(0);
  endtask

  task automatic test_halt_wrap();
    tname = "halt";
    do_reset();
    gen_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    gen_instr(0, 0, 0, 0, 1, 1, 0, 0, 0);
    gen_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_q(0);
    tname = "wrap";
    do_reset();
    for (int k = 0; k < 16; k++) gen_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_q(0);
    @(negedge clk);
    mem_ack = 0;
    #1;
    n_checks++;
    if (instret0 !== 4'd0 || state0 !== 3'd1) begin
      n_errors++; $display("FAIL wrap_final: got instret %0d state %0d, expected 0 and 1", instret0, state0);
    end
  endtask

  task automatic test_back_to_back();
    for (int sel = 0; sel < 2; sel++) begin
      tname = "random";
      do_reset();
      for (int k = 0; k < 40; k++) begin
        int  kind;
        bit  ld, st, nowb, hlt;
        kind = $urandom_range(0, 9);
        ld = (kind == 1 || kind == 2);
        st = (kind == 3 || kind == 4);
        nowb = st || (kind == 5 || kind == 6);
        hlt = (kind == 7);
        gen_instr(1'(sel), ld, st, nowb, hlt, $urandom_range(0, 4), $urandom_range(0, 4),
                  rb(), rb());
      end
      run_q(1'(sel));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_timeout();
    test_branch_irq();
    test_halt_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
